// File: rtl/stereo_stream_generator.sv
// Stereo test-pattern source: programmable raster timing with a textured left
// image and a right image shifted by a disparity latched at each frame start.
module stereo_stream_generator #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FRONT   = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BACK    = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FRONT   = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BACK    = 20,
  parameter int DISP_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [1:0]           mode,
  input  logic [DISP_BITS-1:0] disparity,
  output logic                 de_out,
  output logic                 h_sync_out,
  output logic                 v_sync_out,
  output logic [7:0]           pixel_left,
  output logic [7:0]           pixel_right,
  output logic                 frame_start,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 r_state;
  logic [10:0]            r_h;
  logic [9:0]             r_v;
  logic [1:0]             r_mode;
  logic [DISP_BITS-1:0]   r_disp;
  logic [15:0]            r_fcount;

  logic                   w_active;
  logic                   w_de;
  logic                   w_hs;
  logic                   w_vs;
  logic                   w_fs;
  logic [11:0]            w_hd;
  logic                   w_in_edge;
  logic [7:0]             w_tex_l;
  logic [7:0]             w_tex_r;
  logic [7:0]             w_left;
  logic [7:0]             w_right;

  // Texture f(r,c) = (c*37 ^ c>>3 ^ r*11) mod 256 on 16-bit zero-extended operands.
  function automatic logic [7:0] texture(input logic [15:0] r, input logic [15:0] c);
    logic [15:0] t;
    t = (c * 16'd37) ^ (c >> 3) ^ (r * 16'd11);
    return t[7:0];
  endfunction

  // Frame FSM: raster counters, per-frame latching of mode/disparity, frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_h      <= '0;
      r_v      <= '0;
      r_mode   <= '0;
      r_disp   <= '0;
      r_fcount <= '0;
    end else if (r_state == S_IDLE) begin
      r_h <= '0;
      r_v <= '0;
      if (run) begin
        r_mode  <= mode;
        r_disp  <= disparity;
        r_state <= S_RUN;
      end
    end else begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        if (r_v == V_LAST) begin
          // Frame end: a dropped run only takes effect here, never mid-frame.
          r_v      <= '0;
          r_fcount <= r_fcount + 16'd1;
          if (run) begin
            r_mode <= mode;
            r_disp <= disparity;
          end else begin
            r_state <= S_IDLE;
          end
        end else begin
          r_v <= r_v + 10'd1;
        end
      end else begin
        r_h <= r_h + 11'd1;
      end
    end
  end

  assign w_active  = (r_state == S_RUN);
  assign w_de      = w_active && (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs      = w_active && (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs      = w_active && (r_v >= VS_BEG) && (r_v < VS_END);
  assign w_fs      = w_active && (r_h == '0) && (r_v == '0);
  assign w_hd      = {1'b0, r_h} + 12'(r_disp);
  assign w_in_edge = (w_hd < {1'b0, H_ACT});
  assign w_tex_l   = texture({6'd0, r_v}, {5'd0, r_h});
  assign w_tex_r   = texture({6'd0, r_v}, {4'd0, w_hd});

  // Pixel selection by latched mode; right image goes black past the active edge.
  always_comb begin
    w_left  = 8'd0;
    w_right = 8'd0;
    if (w_de) begin
      case (r_mode)
        2'd0: begin
          w_left  = w_tex_l;
          w_right = w_in_edge ? w_tex_r : 8'd0;
        end
        2'd1: begin
          w_left  = 8'h80;
          w_right = 8'h80;
        end
        2'd2: begin
          w_left  = r_h[7:0];
          w_right = w_in_edge ? w_hd[7:0] : 8'd0;
        end
        default: begin
          w_left  = 8'd0;
          w_right = 8'd0;
        end
      endcase
    end
  end

  // Registered raster decode: outputs trail the counters by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_out      <= 1'b0;
      h_sync_out  <= 1'b0;
      v_sync_out  <= 1'b0;
      pixel_left  <= 8'd0;
      pixel_right <= 8'd0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      de_out      <= w_de;
      h_sync_out  <= w_hs;
      v_sync_out  <= w_vs;
      pixel_left  <= w_left;
      pixel_right <= w_right;
      frame_start <= w_fs;
      busy        <= w_active;
    end
  end

  assign frame_count = r_fcount;

endmodule
